// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle controller and its datapath:
// FSM state encodings, opcode constants, PC source select codes and the decoded control bundle.
package mc_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [3:0] {
        CLS_NONE = 4'd0,
        CLS_R    = 4'd1,
        CLS_LW   = 4'd2,
        CLS_SW   = 4'd3,
        CLS_BEQ  = 4'd4,
        CLS_J    = 4'd5,
        CLS_JAL  = 4'd6,
        CLS_ORI  = 4'd7,
        CLS_LUI  = 4'd8
    } op_class_t;

    typedef struct packed {
        op_class_t  op_class;
        logic [1:0] aluop;
        logic       branch;
        logic       alusrc;
        logic       regdst;
        logic       jump;
        logic       link;
        logic       immediate_or;
        logic       immediate_load_upper;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'('0);

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: maps instruction[31:26] to the control bundle
// and flags opcodes this controller does not implement.
module mc_decode
    import mc_control_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // Opcode to control bundle; every field not listed for an opcode stays 0.
    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.op_class = CLS_R;
                ctrl.aluop    = ALUOP_FUNC;
                ctrl.regdst   = 1'b1;
            end
            OP_LW: begin
                ctrl.op_class = CLS_LW;
                ctrl.alusrc   = 1'b1;
            end
            OP_SW: begin
                ctrl.op_class = CLS_SW;
                ctrl.alusrc   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.op_class = CLS_BEQ;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.branch   = 1'b1;
            end
            OP_J: begin
                ctrl.op_class = CLS_J;
                ctrl.jump     = 1'b1;
            end
            OP_JAL: begin
                ctrl.op_class = CLS_JAL;
                ctrl.jump     = 1'b1;
                ctrl.link     = 1'b1;
            end
            OP_ORI: begin
                ctrl.op_class     = CLS_ORI;
                ctrl.immediate_or = 1'b1;
                ctrl.alusrc       = 1'b1;
            end
            OP_LUI: begin
                ctrl.op_class             = CLS_LUI;
                ctrl.immediate_load_upper = 1'b1;
                ctrl.alusrc               = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller. Strobes are decoded from the
// registered state; decoded control fields are captured on DECODE exit.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic [5:0]          opcode,
    input  logic                instr_ack,
    input  logic                data_ack,
    input  logic                do_branch,
    input  logic                do_jump,
    output logic                instr_req,
    output logic                ir_write,
    output logic                data_req,
    output logic                data_we,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [1:0]          aluop,
    output logic                branch,
    output logic                alusrc,
    output logic                regdst,
    output logic                jump,
    output logic                link,
    output logic                immediate_or,
    output logic                immediate_load_upper,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    state_t                state_r;
    state_t                state_s;
    ctrl_t                 ctrl_r;
    ctrl_t                 dec_ctrl_s;
    logic                  dec_illegal_s;
    logic                  armed_r;
    logic                  req_hold_r;
    logic                  retire_s;
    logic [RETIRE_W-1:0]   retired_r;

    mc_decode u_decode (
        .opcode  (opcode),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s)
    );

    // Next-state and strobe generation for the instruction sequence.
    always_comb begin
        state_s    = state_r;
        instr_req  = 1'b0;
        ir_write   = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PC4;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        retire_s   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                // armed_r keeps the request low until the first edge after reset release.
                instr_req = armed_r & (run | req_hold_r);
                if (instr_req && instr_ack) begin
                    ir_write = 1'b1;
                    state_s  = ST_DECODE;
                end else begin
                    state_s  = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal_s) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    state_s  = ST_FETCH;
                end else begin
                    state_s  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (ctrl_r.op_class)
                    CLS_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = do_branch ? PC_SRC_BRANCH : PC_SRC_PC4;
                        retire_s = 1'b1;
                        state_s  = ST_FETCH;
                    end
                    CLS_J: begin
                        pc_write = 1'b1;
                        pc_src   = do_jump ? PC_SRC_JUMP : PC_SRC_PC4;
                        retire_s = 1'b1;
                        state_s  = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = do_jump ? PC_SRC_JUMP : PC_SRC_PC4;
                        reg_write = 1'b1;
                        retire_s  = 1'b1;
                        state_s   = ST_FETCH;
                    end
                    CLS_LW, CLS_SW: begin
                        state_s = ST_MEM;
                    end
                    default: begin
                        state_s = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                data_req = 1'b1;
                data_we  = (ctrl_r.op_class == CLS_SW);
                if (data_ack) begin
                    if (ctrl_r.op_class == CLS_SW) begin
                        pc_write = 1'b1;
                        retire_s = 1'b1;
                        state_s  = ST_FETCH;
                    end else begin
                        state_s  = ST_WB;
                    end
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (ctrl_r.op_class == CLS_LW);
                pc_write   = 1'b1;
                retire_s   = 1'b1;
                state_s    = ST_FETCH;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State, request hold, decoded-control capture and retirement counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_FETCH;
            ctrl_r     <= CTRL_NONE;
            armed_r    <= 1'b0;
            req_hold_r <= 1'b0;
            retired_r  <= {RETIRE_W{1'b0}};
        end else begin
            state_r    <= state_s;
            armed_r    <= 1'b1;
            req_hold_r <= instr_req & ~instr_ack;
            if (state_r == ST_DECODE) begin
                ctrl_r <= dec_ctrl_s;
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign state                = state_r;
    assign retired              = retired_r;
    assign aluop                = ctrl_r.aluop;
    assign branch               = ctrl_r.branch;
    assign alusrc               = ctrl_r.alusrc;
    assign regdst               = ctrl_r.regdst;
    assign jump                 = ctrl_r.jump;
    assign link                 = ctrl_r.link;
    assign immediate_or         = ctrl_r.immediate_or;
    assign immediate_load_upper = ctrl_r.immediate_load_upper;

endmodule
